// File: rtl/operand_fetch.sv
// operand_fetch: read-side sequencer for the 32x32 register file.
// Latches rs/rt/rd from decode, drives the file read addresses from the
// latched indices, captures A/B (with $0 and same-cycle writeback bypass),
// and holds them for execute under a valid/ready handshake.
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. in_ready is high only in IDLE. Once out_valid rises, out_a,
// out_b and the indices stay put until the consume edge, except for the
// optional writeback coherence updates while waiting.
module operand_fetch #(
    parameter int DW       = 32,
    parameter int AW       = 5,
    parameter bit COHERENT = 1'b1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          flush,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [AW-1:0] in_rs,
    input  logic [AW-1:0] in_rt,
    input  logic [AW-1:0] in_rd,
    output logic [AW-1:0] rf_rs,
    output logic [AW-1:0] rf_rt,
    input  logic [DW-1:0] rf_rs_data,
    input  logic [DW-1:0] rf_rt_data,
    input  logic          wb_we,
    input  logic [AW-1:0] wb_addr,
    input  logic [DW-1:0] wb_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_a,
    output logic [DW-1:0] out_b,
    output logic [AW-1:0] out_rs,
    output logic [AW-1:0] out_rt,
    output logic [AW-1:0] out_rd,
    output logic [1:0]    dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_CAPTURE = 2'd1,
        S_VALID   = 2'd2
    } state_t;

    state_t        state_q;
    logic          in_ready_q;
    logic          out_valid_q;
    logic [DW-1:0] a_q;
    logic [DW-1:0] b_q;
    logic [AW-1:0] rs_q;
    logic [AW-1:0] rt_q;
    logic [AW-1:0] rd_q;

    logic          wb_live;
    logic          hit_rs;
    logic          hit_rt;
    logic [DW-1:0] a_d;
    logic [DW-1:0] b_d;

    // A writeback to $0 is discarded by the file, so it never counts as a hit.
    always_comb begin
        wb_live = wb_we && (wb_addr != '0);
        hit_rs  = wb_live && (wb_addr == rs_q);
        hit_rt  = wb_live && (wb_addr == rt_q);
    end

    // Capture value: $0 wins, then the in-flight writeback (the file only
    // sees it after this edge), then the file's combinational read data.
    always_comb begin
        a_d = rf_rs_data;
        b_d = rf_rt_data;
        if (rs_q == '0) begin
            a_d = '0;
        end else if (hit_rs) begin
            a_d = wb_data;
        end
        if (rt_q == '0) begin
            b_d = '0;
        end else if (hit_rt) begin
            b_d = wb_data;
        end
    end

    // Sequencer: state, handshake flags, latched indices and held operands.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
            rs_q        <= '0;
            rt_q        <= '0;
            rd_q        <= '0;
        end else if (flush) begin
            // Abort wins over accept/capture/consume; operands stay as they are.
            state_q     <= S_IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (in_valid && in_ready_q) begin
                        rs_q       <= in_rs;
                        rt_q       <= in_rt;
                        rd_q       <= in_rd;
                        in_ready_q <= 1'b0;
                        state_q    <= S_CAPTURE;
                    end
                end
                S_CAPTURE: begin
                    a_q         <= a_d;
                    b_q         <= b_d;
                    out_valid_q <= 1'b1;
                    state_q     <= S_VALID;
                end
                S_VALID: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= S_IDLE;
                    end else if (COHERENT) begin
                        if (hit_rs) a_q <= wb_data;
                        if (hit_rt) b_q <= wb_data;
                    end
                end
                default: begin
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                    state_q     <= S_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_a     = a_q;
    assign out_b     = b_q;
    assign out_rs    = rs_q;
    assign out_rt    = rt_q;
    assign out_rd    = rd_q;
    assign rf_rs     = rs_q;
    assign rf_rt     = rt_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_operand_fetch.sv
// Bench for operand_fetch: one coherent and one frozen instance share the
// same stimulus; a register-file array feeds both, and a transaction-level
// model predicts every output after each rising edge.
module tb_operand_fetch;

    logic        clk = 1'b0;
    logic        reset, flush, in_valid, out_ready, wb_we;
    logic [4:0]  in_rs, in_rt, in_rd, wb_addr;
    logic [31:0] wb_data;

    logic [31:0] arch [32];

    logic        c_in_ready, c_out_valid, f_in_ready, f_out_valid;
    logic [4:0]  c_rf_rs, c_rf_rt, c_out_rs, c_out_rt, c_out_rd;
    logic [4:0]  f_rf_rs, f_rf_rt, f_out_rs, f_out_rt, f_out_rd;
    logic [31:0] c_rs_data, c_rt_data, c_out_a, c_out_b;
    logic [31:0] f_rs_data, f_rt_data, f_out_a, f_out_b;
    logic [1:0]  c_dbg, f_dbg;

    assign c_rs_data = arch[c_rf_rs];
    assign c_rt_data = arch[c_rf_rt];
    assign f_rs_data = arch[f_rf_rs];
    assign f_rt_data = arch[f_rf_rt];

    always #5 clk = ~clk;

    operand_fetch #(.DW(32), .AW(5), .COHERENT(1'b1)) u_coh (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(c_in_ready),
        .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd),
        .rf_rs(c_rf_rs), .rf_rt(c_rf_rt),
        .rf_rs_data(c_rs_data), .rf_rt_data(c_rt_data),
        .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
        .out_valid(c_out_valid), .out_ready(out_ready),
        .out_a(c_out_a), .out_b(c_out_b),
        .out_rs(c_out_rs), .out_rt(c_out_rt), .out_rd(c_out_rd),
        .dbg_state(c_dbg)
    );

    operand_fetch #(.DW(32), .AW(5), .COHERENT(1'b0)) u_frz (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(f_in_ready),
        .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd),
        .rf_rs(f_rf_rs), .rf_rt(f_rf_rt),
        .rf_rs_data(f_rs_data), .rf_rt_data(f_rt_data),
        .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
        .out_valid(f_out_valid), .out_ready(out_ready),
        .out_a(f_out_a), .out_b(f_out_b),
        .out_rs(f_out_rs), .out_rt(f_out_rt), .out_rd(f_out_rd),
        .dbg_state(f_dbg)
    );

    int n_assert = 0;
    int n_fail   = 0;

    // Model: 0 = waiting for a request, 1 = operands being read, 2 = offered.
    int          m_phase;
    logic [4:0]  m_rs, m_rt, m_rd;
    logic [31:0] m_a_coh, m_b_coh, m_a_frz, m_b_frz;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Architectural value of a register once this edge's writeback has landed.
    function automatic logic [31:0] arch_after(input logic [4:0] idx);
        if (idx == 5'd0) return 32'h0;
        if (wb_we && wb_addr == idx) return wb_data;
        return arch[idx];
    endfunction

    task automatic model_clear();
        m_phase = 0;
        m_rs = '0; m_rt = '0; m_rd = '0;
        m_a_coh = '0; m_b_coh = '0; m_a_frz = '0; m_b_frz = '0;
    endtask

    task automatic model_edge();
        if (reset) begin
            model_clear();
        end else if (flush) begin
            m_phase = 0;
        end else begin
            case (m_phase)
                0: if (in_valid) begin
                    m_rs = in_rs; m_rt = in_rt; m_rd = in_rd;
                    m_phase = 1;
                end
                1: begin
                    m_a_coh = arch_after(m_rs); m_b_coh = arch_after(m_rt);
                    m_a_frz = m_a_coh;          m_b_frz = m_b_coh;
                    m_phase = 2;
                end
                default: begin
                    if (out_ready) m_phase = 0;
                    else begin
                        // A coherent operand always equals the current register value.
                        m_a_coh = arch_after(m_rs);
                        m_b_coh = arch_after(m_rt);
                    end
                end
            endcase
        end
        if (wb_we && wb_addr != 5'd0) arch[wb_addr] = wb_data;
    endtask

    task automatic check_all();
        chk("coh.in_ready",  {31'b0, c_in_ready},  {31'b0, m_phase == 0});
        chk("coh.out_valid", {31'b0, c_out_valid}, {31'b0, m_phase == 2});
        chk("coh.out_rs", {27'b0, c_out_rs}, {27'b0, m_rs});
        chk("coh.out_rt", {27'b0, c_out_rt}, {27'b0, m_rt});
        chk("coh.out_rd", {27'b0, c_out_rd}, {27'b0, m_rd});
        chk("coh.rf_rs",  {27'b0, c_rf_rs},  {27'b0, m_rs});
        chk("coh.rf_rt",  {27'b0, c_rf_rt},  {27'b0, m_rt});
        chk("coh.out_a", c_out_a, m_a_coh);
        chk("coh.out_b", c_out_b, m_b_coh);
        chk("frz.in_ready",  {31'b0, f_in_ready},  {31'b0, m_phase == 0});
        chk("frz.out_valid", {31'b0, f_out_valid}, {31'b0, m_phase == 2});
        chk("frz.out_rs", {27'b0, f_out_rs}, {27'b0, m_rs});
        chk("frz.out_rt", {27'b0, f_out_rt}, {27'b0, m_rt});
        chk("frz.out_rd", {27'b0, f_out_rd}, {27'b0, m_rd});
        chk("frz.rf_rs",  {27'b0, f_rf_rs},  {27'b0, m_rs});
        chk("frz.rf_rt",  {27'b0, f_rf_rt},  {27'b0, m_rt});
        chk("frz.out_a", f_out_a, m_a_frz);
        chk("frz.out_b", f_out_b, m_b_frz);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        model_edge();
        check_all();
    endtask

    task automatic quiet();
        in_valid = 1'b0; flush = 1'b0; wb_we = 1'b0; out_ready = 1'b0;
        wb_addr = '0; wb_data = '0;
    endtask

    task automatic request(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
        in_valid = 1'b1; in_rs = rs; in_rt = rt; in_rd = rd;
    endtask

    logic [31:0] old5;

    initial begin
        for (int i = 0; i < 32; i++) arch[i] = (i == 0) ? 32'h0 : $urandom;
        reset = 1'b1; in_rs = '0; in_rt = '0; in_rd = '0;
        quiet();
        model_clear();
        step(); step();
        chk("reset.out_a", c_out_a, 32'h0);
        reset = 1'b0;
        step();

        // Basic read
        arch[8] = 32'h0000_1234; arch[9] = 32'hFFFF_0001;
        request(5'd8, 5'd9, 5'd10); out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        chk("basic.out_valid", {31'b0, c_out_valid}, 32'd1);
        chk("basic.out_a", c_out_a, 32'h0000_1234);
        chk("basic.out_b", c_out_b, 32'hFFFF_0001);
        chk("basic.out_rd", {27'b0, c_out_rd}, 32'd10);
        step();
        chk("basic.idle", {31'b0, c_in_ready}, 32'd1);

        // Writeback bypass during capture, then the $0 case
        quiet(); request(5'd8, 5'd9, 5'd3);
        step();
        in_valid = 1'b0; wb_we = 1'b1; wb_addr = 5'd8; wb_data = 32'hDEAD_BEEF;
        step();
        chk("bypass.coh_a", c_out_a, 32'hDEAD_BEEF);
        chk("bypass.frz_a", f_out_a, 32'hDEAD_BEEF);
        quiet(); out_ready = 1'b1;
        step();
        quiet(); request(5'd0, 5'd9, 5'd3);
        step();
        in_valid = 1'b0; wb_we = 1'b1; wb_addr = 5'd0; wb_data = 32'h1234_5678;
        step();
        chk("zero.out_a", c_out_a, 32'h0);
        quiet(); out_ready = 1'b1;
        step();

        // Backpressure with a writeback to rt while waiting
        quiet(); request(5'd8, 5'd9, 5'd1);
        step();
        in_valid = 1'b0;
        step();
        for (int k = 0; k < 4; k++) begin
            request(5'(k), 5'(k + 1), 5'(k + 2));
            in_valid = k[0];
            wb_we = (k == 1); wb_addr = 5'd9; wb_data = 32'h55;
            step();
            chk("bp.in_ready", {31'b0, c_in_ready}, 32'd0);
        end
        chk("bp.coh_b", c_out_b, 32'h55);
        chk("bp.frz_b", f_out_b, 32'hFFFF_0001);
        quiet(); out_ready = 1'b1;
        step();

        // rs == rt, one writeback updates both held operands
        old5 = arch[5];
        quiet(); request(5'd5, 5'd5, 5'd7);
        step();
        in_valid = 1'b0;
        step();
        wb_we = 1'b1; wb_addr = 5'd5; wb_data = 32'hA5;
        step();
        chk("same.coh_a", c_out_a, 32'hA5);
        chk("same.coh_b", c_out_b, 32'hA5);
        chk("same.frz_a", f_out_a, old5);
        quiet(); out_ready = 1'b1;
        step();

        // Flush in VALID while execute is also consuming
        quiet(); request(5'd3, 5'd4, 5'd5);
        step();
        in_valid = 1'b0;
        step();
        flush = 1'b1; out_ready = 1'b1;
        step();
        chk("flush.out_valid", {31'b0, c_out_valid}, 32'd0);
        chk("flush.in_ready", {31'b0, c_in_ready}, 32'd1);
        quiet();

        // Asynchronous reset in the middle of CAPTURE
        request(5'd6, 5'd7, 5'd8);
        step();
        in_valid = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        model_clear();
        check_all();
        chk("rst.in_ready", {31'b0, c_in_ready}, 32'd1);
        chk("rst.out_a", c_out_a, 32'h0);
        step();
        reset = 1'b0;

        // Back-to-back requests, in_valid held high
        quiet(); out_ready = 1'b1; request(5'd1, 5'd2, 5'd3);
        step();
        request(5'd4, 5'd5, 5'd6);
        step();
        step();
        chk("b2b.ready_after_consume", {31'b0, c_in_ready}, 32'd1);
        step();
        chk("b2b.second_rs", {27'b0, c_out_rs}, 32'd4);
        in_valid = 1'b0;
        step(); step();

        // Random traffic
        for (int n = 0; n < 400; n++) begin
            in_valid  = ($urandom_range(0, 2) != 0);
            in_rs     = 5'($urandom_range(0, 31));
            in_rt     = ($urandom_range(0, 3) == 0) ? in_rs : 5'($urandom_range(0, 31));
            in_rd     = 5'($urandom_range(0, 31));
            out_ready = ($urandom_range(0, 2) == 0);
            flush     = ($urandom_range(0, 15) == 0);
            wb_we     = ($urandom_range(0, 1) == 1);
            case ($urandom_range(0, 3))
                0: wb_addr = m_rs;
                1: wb_addr = m_rt;
                2: wb_addr = 5'd0;
                default: wb_addr = 5'($urandom_range(0, 31));
            endcase
            wb_data = $urandom;
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
